// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : oversampling UART receiver
//
// Receives asynchronous serial frames (start, DATA_SIZE data bits LSB first,
// optional odd/even parity bit, STOP_SIZE stop bits) on Rx. The line is
// resynchronised into the clk domain and sampled once per bit, at the bit
// centre, using an oversampling tick of SAMPLE ticks per bit.
//
// Ports
//   clk          system clock, rising-edge
//   rst_n        asynchronous active-low reset
//   Rx           serial line, idles high, asynchronous to clk
//   d_out        last received word, LSB-aligned, unused upper bits 0
//   d_out_valid  one-clk pulse when a frame completes
//   parity_err   parity mismatch flag of the last completed frame
//   frame_err    stop-bit error flag of the last completed frame
//   busy         high whenever the receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int SYS_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_SIZE = 8,
  parameter int STOP_SIZE = 1,
  parameter int SAMPLE    = 16,
  parameter int PARITY    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       Rx,
  output logic [7:0] d_out,
  output logic       d_out_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV  = SYS_FREQ / (BAUD_RATE * SAMPLE);
  localparam int DW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW   = $clog2(SAMPLE);
  localparam int HALF = SAMPLE / 2;
  localparam logic PAR_EXP = (PARITY == 1) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam state_t AFTER_DATA = (PARITY != 0) ? ST_PARITY : ST_STOP;

  // XOR of all data bits and the received parity bit
  function automatic logic par_calc(input logic [7:0] data, input logic par_bit);
    return (^data) ^ par_bit;
  endfunction

  state_t          r_state;
  state_t          w_state_nx;
  logic [1:0]      r_sync;
  logic            w_rx_s;
  logic [DW-1:0]   r_div;
  logic [TW-1:0]   r_tcnt;
  logic [3:0]      r_bit;
  logic [7:0]      r_shift;
  logic            r_par_err;
  logic            r_stop_err;
  logic            r_armed;
  logic            r_fin;
  logic            w_tick;
  logic            w_half;
  logic            w_full;
  logic            w_start;
  logic            w_finish;
  logic [7:0]      r_d_out;
  logic            r_valid;
  logic            r_parity_err;
  logic            r_frame_err;
  logic            r_busy;

  assign w_rx_s = r_sync[1];
  assign w_tick = (r_div == DW'(DIV - 1));
  assign w_half = w_tick && (r_tcnt == TW'(HALF - 1));
  assign w_full = w_tick && (r_tcnt == TW'(SAMPLE - 1));

  // Two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], Rx};
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state logic and frame start/finish strobes
  always_comb begin
    w_state_nx = r_state;
    w_start    = 1'b0;
    w_finish   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_armed && !w_rx_s) begin
          w_state_nx = ST_START;
          w_start    = 1'b1;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_half) begin
          w_state_nx = w_rx_s ? ST_IDLE : ST_DATA;
        end else begin
          w_state_nx = ST_START;
        end
      end
      ST_DATA: begin
        if (w_full && (r_bit == 4'(DATA_SIZE - 1))) begin
          w_state_nx = AFTER_DATA;
        end else begin
          w_state_nx = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (w_full) begin
          w_state_nx = ST_STOP;
        end else begin
          w_state_nx = ST_PARITY;
        end
      end
      ST_STOP: begin
        // r_fin marks that the last stop bit was sampled on the previous clk
        if (r_fin) begin
          w_state_nx = ST_IDLE;
          w_finish   = 1'b1;
        end else begin
          w_state_nx = ST_STOP;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // Baud divider and per-bit tick counter; both held at zero while idle so a
  // detected start edge always begins counting from a clean phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_tcnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_div  <= '0;
      r_tcnt <= '0;
    end else begin
      r_div <= w_tick ? DW'(0) : r_div + DW'(1);
      if (w_tick) begin
        if ((r_state == ST_START && w_half) || w_full) begin
          r_tcnt <= '0;
        end else begin
          r_tcnt <= r_tcnt + TW'(1);
        end
      end
    end
  end

  // Armed flag: a line stuck low after a bad stop bit must go high before
  // another start edge is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed <= 1'b1;
    end else if (r_state == ST_IDLE && w_rx_s) begin
      r_armed <= 1'b1;
    end else if (r_state == ST_STOP && w_full && !r_fin &&
                 r_bit == 4'(STOP_SIZE - 1) && !w_rx_s) begin
      r_armed <= 1'b0;
    end
  end

  // Bit sampling: data shift-in, parity check, stop-bit check
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit      <= 4'd0;
      r_shift    <= 8'd0;
      r_par_err  <= 1'b0;
      r_stop_err <= 1'b0;
      r_fin      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_bit      <= 4'd0;
            r_shift    <= 8'd0;
            r_par_err  <= 1'b0;
            r_stop_err <= 1'b0;
            r_fin      <= 1'b0;
          end
        end
        ST_START: begin
          r_bit <= 4'd0;
        end
        ST_DATA: begin
          if (w_full) begin
            r_shift[r_bit[2:0]] <= w_rx_s;
            r_bit <= (r_bit == 4'(DATA_SIZE - 1)) ? 4'd0 : r_bit + 4'd1;
          end
        end
        ST_PARITY: begin
          if (w_full) begin
            r_par_err <= (par_calc(r_shift, w_rx_s) != PAR_EXP);
          end
        end
        ST_STOP: begin
          if (w_full && !r_fin) begin
            if (!w_rx_s) begin
              r_stop_err <= 1'b1;
            end
            if (r_bit == 4'(STOP_SIZE - 1)) begin
              r_fin <= 1'b1;
            end else begin
              r_bit <= r_bit + 4'd1;
            end
          end
        end
        default: begin
          r_bit <= 4'd0;
        end
      endcase
    end
  end

  // Output registers: result words update together when a frame completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_d_out      <= 8'd0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_valid <= w_finish;
      r_busy  <= (w_state_nx != ST_IDLE);
      if (w_finish) begin
        r_d_out      <= r_shift;
        r_parity_err <= r_par_err;
        r_frame_err  <= r_stop_err;
      end
    end
  end

  assign d_out       = r_d_out;
  assign d_out_valid = r_valid;
  assign parity_err  = r_parity_err;
  assign frame_err   = r_frame_err;
  assign busy        = r_busy;

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter SYS_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, line bit rate in bits/s.
REQ-003 Parameter DATA_SIZE, default 8, data bits per frame; legal range 5..8.
REQ-004 Parameter STOP_SIZE, default 1, stop bits per frame; legal values 1 or 2.
REQ-005 Parameter SAMPLE, default 16, oversampling ticks per bit; must be even and ≥4.
REQ-006 Parameter PARITY, default 2, parity mode: 0 = none, 1 = odd, 2 = even.
REQ-007 clk  input  1  system clock; all state updates on the rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 Rx  input  1  serial line; idles high; asynchronous to clk.
REQ-010 d_out  output  8  received data word, LSB-aligned; bits at or above DATA_SIZE are 0.
REQ-011 d_out_valid  output  1  single-clk pulse marking frame completion.
REQ-012 parity_err  output  1  parity mismatch flag for the last completed frame.
REQ-013 frame_err  output  1  stop-bit error flag for the last completed frame.
REQ-014 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-015 Rx shall pass through a 2-flop synchronizer (rx_s) whose flops reset to 1; all decisions shall use rx_s.
REQ-016 Oversample tick generation:
- DIV = SYS_FREQ/(BAUD_RATE*SAMPLE), integer truncation.
- Tick pulses 1 clk every DIV clks.
- Divider and tick counter restart at 0 on start detection.
REQ-017 FSM states shall be IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE arms only after rx_s has been seen high (armed flag, set at reset); armed and rx_s==0 -> START on the next clk.
REQ-019 START: after SAMPLE/2 ticks, sample rx_s.
- 0 -> DATA.
- 1 -> IDLE (false start); no valid pulse, error flags unchanged.
REQ-020 DATA: sample rx_s every SAMPLE ticks into a shift register, LSB first.
- After DATA_SIZE samples -> PARITY if PARITY≠0, else STOP.
REQ-021 PARITY: sample once after SAMPLE ticks.
- Error = XOR of data bits and the parity bit ≠ expected.
- Expected is 1 for odd, 0 for even.
REQ-022 STOP: sample STOP_SIZE bits, each after SAMPLE ticks; frame error if any sampled stop bit is 0.
REQ-023 On the clk after the last stop sample, in a single cycle:
- d_out, parity_err and frame_err update together.
- d_out_valid = 1 for exactly that clk.
- FSM -> IDLE.
REQ-024 d_out, parity_err and frame_err shall hold until the next completed frame; a frame with errors still updates d_out.
REQ-025 If the last stop bit is 0, armed shall clear, so a held-low (break) line generates no further frames until rx_s returns high.
REQ-026 Rx transitions during a frame shall be ignored except at sample points; only one sample is taken per bit.
REQ-027 Latency: d_out_valid shall assert a fixed number of clks after the Rx falling edge, equal to 2 (sync) + 1 (detect) + DIV*(SAMPLE/2 + SAMPLE*(DATA_SIZE + P + STOP_SIZE)) + 1, where P = 1 if PARITY≠0, else 0.
REQ-028 A new start edge accepted in the cycle after d_out_valid shall be received correctly (back-to-back frames).

Reset
REQ-029 While rst_n=0, regardless of clk:
- Outputs: d_out=0, d_out_valid=0, parity_err=0, frame_err=0, busy=0.
- Internal state: FSM=IDLE, synchronizer=1, armed=1, counters=0.
REQ-030 Reset asserted mid-frame shall discard the partial frame with no valid pulse; reception restarts only on a fresh start edge after release.

Verification
Common setup: SYS_FREQ=16, BAUD_RATE=1, SAMPLE=16 (DIV=1, 16 clks/bit), DATA_SIZE=8, STOP_SIZE=1, PARITY=2.
REQ-031 Send 0xA5 with parity 0 and stop 1 -> one d_out_valid pulse, d_out=0xA5, parity_err=0, frame_err=0, busy=0 afterwards.
REQ-032 Send 0x3C with parity bit 1 -> d_out=0x3C, parity_err=1, frame_err=0.
REQ-033 Send 0x55 with stop bit 0, then hold Rx low 200 clks -> exactly one pulse with frame_err=1; no further pulses until Rx goes high and a new start bit arrives.
REQ-034 Rx low for 4 clks, then high -> FSM returns to IDLE; no d_out_valid; previous d_out and flags are unchanged.
REQ-035 Assert rst_n=0 during data bit 3 of a frame, release, then send 0x81 -> all outputs 0 during reset; exactly one pulse with d_out=0x81.
REQ-036 Send 0x00 then 0xFF back-to-back with no idle gap -> two pulses in order, d_out=0x00 then 0xFF, no errors.
